mc_chroma_sched: RTL and testbench

- Sequencer for one chroma MC prediction block. It drives one row of horizontal 4-tap chroma filters and a 4-row window feeding a vertical 4-tap chroma filter row.
- Per block it issues reference-row fetches, shifts horizontally filtered rows into the window, and marks when the vertical stage output row is valid.
- Sits between the chroma reference fetch buffer and the horizontal/vertical chroma filter datapath in rec_mc.

---
 rtl/mc_chroma_sched.sv | 104 ++++++++++
 tb/tb_mc_chroma_sched.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mc_chroma_sched.sv
// Chroma MC block sequencer: walks reference rows into the horizontal filter,
// shifts results into the 4-row vertical window and flags valid output rows.
module mc_chroma_sched #(
  parameter int ROW_W = 6,
  parameter int H_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       frac_x_i,
  input  logic [2:0]       frac_y_i,
  input  logic [H_W-1:0]   blk_h_i,
  output logic             ref_req_o,
  output logic [ROW_W-1:0] ref_row_o,
  input  logic             ref_vld_i,
  output logic [2:0]       frac_x_o,
  output logic [2:0]       frac_y_o,
  output logic             win_shift_o,
  output logic             out_valid_o,
  output logic [H_W-1:0]   out_row_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [2:0]     frac_x;
    logic [2:0]     frac_y;
    logic [H_W-1:0] blk_h;
  } cfg_t;

  state_t          state, state_nxt;
  cfg_t            cfg_q;
  logic [H_W:0]    k_q;
  logic [ROW_W-1:0] ofs_q;
  logic [H_W:0]    n_rows, fill_m1;
  logic            legal, accept, fire, last;

  assign legal  = (blk_h_i == H_W'(2)) || (blk_h_i == H_W'(4)) ||
                  (blk_h_i == H_W'(8)) || (blk_h_i == H_W'(16));
  assign accept = (state == IDLE) && start_i && legal;
  assign fire   = (state == FETCH) && ref_vld_i;

  // Fractional vertical filtering needs one row above and two below the block.
  assign n_rows  = (cfg_q.frac_y != 3'd0) ? ({1'b0, cfg_q.blk_h} + (H_W+1)'(3))
                                          : {1'b0, cfg_q.blk_h};
  assign fill_m1 = (cfg_q.frac_y != 3'd0) ? (H_W+1)'(3) : '0;
  assign last    = (k_q == n_rows - (H_W+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ref_req_o   = 1'b0;
    win_shift_o = 1'b0;
    done_o      = 1'b0;
    busy_o      = (state != IDLE);
    case (state)
      IDLE:  if (accept) state_nxt = FETCH;
      FETCH: begin
        ref_req_o   = 1'b1;
        win_shift_o = ref_vld_i;
        if (ref_vld_i && last) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = DONE;
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q       <= '0;
      k_q         <= '0;
      ofs_q       <= '0;
      out_valid_o <= 1'b0;
      out_row_o   <= '0;
    end else begin
      if (accept) begin
        cfg_q <= '{frac_x: frac_x_i, frac_y: frac_y_i, blk_h: blk_h_i};
        k_q   <= '0;
        ofs_q <= (frac_y_i != 3'd0) ? {ROW_W{1'b1}} : '0;
      end else if (fire) begin
        k_q   <= k_q + (H_W+1)'(1);
        ofs_q <= ofs_q + ROW_W'(1);
      end
      // Window holds a full vertical tap set once fill-1 rows have been shifted.
      out_valid_o <= fire && (k_q >= fill_m1);
      if (fire && (k_q >= fill_m1)) out_row_o <= H_W'(k_q - fill_m1);
    end
  end

  assign ref_row_o = ofs_q;
  assign frac_x_o  = cfg_q.frac_x;
  assign frac_y_o  = cfg_q.frac_y;

endmodule

// File: tb/tb_mc_chroma_sched.sv
// Directed bench for mc_chroma_sched: cycle-by-cycle checks of fetch, shift,
// output marking and completion across frac_y cases, stalls and stray inputs.
module tb_mc_chroma_sched;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic [2:0] frac_x_i = '0, frac_y_i = '0;
  logic [4:0] blk_h_i = '0;
  logic       ref_req_o;
  logic [5:0] ref_row_o;
  logic       ref_vld_i = 1'b0;
  logic [2:0] frac_x_o, frac_y_o;
  logic       win_shift_o, out_valid_o, busy_o, done_o;
  logic [4:0] out_row_o;

  int checks = 0;
  int failures = 0;
  int cyc;

  mc_chroma_sched #(.ROW_W(6), .H_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .frac_x_i(frac_x_i),
    .frac_y_i(frac_y_i), .blk_h_i(blk_h_i), .ref_req_o(ref_req_o),
    .ref_row_o(ref_row_o), .ref_vld_i(ref_vld_i), .frac_x_o(frac_x_o),
    .frac_y_o(frac_y_o), .win_shift_o(win_shift_o), .out_valid_o(out_valid_o),
    .out_row_o(out_row_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".req"}, ref_req_o, 0);
    chk({tag, ".row"}, ref_row_o, 0);
    chk({tag, ".shift"}, win_shift_o, 0);
    chk({tag, ".ov"}, out_valid_o, 0);
    chk({tag, ".orow"}, out_row_o, 0);
    chk({tag, ".busy"}, busy_o, 0);
    chk({tag, ".done"}, done_o, 0);
    chk({tag, ".fx"}, frac_x_o, 0);
    chk({tag, ".fy"}, frac_y_o, 0);
  endtask

  task automatic cyc_chk(input string tag, input logic req, input logic [5:0] row,
                         input logic shift, input logic ov, input int orow,
                         input logic busy, input logic done,
                         input logic [2:0] fx, input logic [2:0] fy);
    chk({tag, ".req"}, ref_req_o, req);
    if (req) chk({tag, ".row"}, ref_row_o, row);
    chk({tag, ".shift"}, win_shift_o, shift);
    chk({tag, ".ov"}, out_valid_o, ov);
    if (ov) chk({tag, ".orow"}, out_row_o, 5'(orow));
    chk({tag, ".busy"}, busy_o, busy);
    chk({tag, ".done"}, done_o, done);
    chk({tag, ".fx"}, frac_x_o, fx);
    chk({tag, ".fy"}, frac_y_o, fy);
  endtask

  // Drives one block from the IDLE cycle of its start; returns the cycle index
  // (start cycle = 0) at which done_o was seen. Ends #1 into the cycle after DONE.
  task automatic run_blk(input string tag, input logic [2:0] fx, input logic [2:0] fy,
                         input int bh, input int stall_ofs, input int stall_len,
                         input logic stray, output int done_cyc);
    int base, n, fill, c, orow_e;
    logic ov_e;
    base = (fy != 0) ? -1 : 0;
    n    = (fy != 0) ? bh + 3 : bh;
    fill = (fy != 0) ? 4 : 1;
    done_cyc = -1;
    start_i = 1'b1; frac_x_i = fx; frac_y_i = fy; blk_h_i = 5'(bh); ref_vld_i = 1'b1;
    @(negedge clk);
    chk({tag, ".c0busy"}, busy_o, 0);
    @(posedge clk); #1;
    start_i = 1'b0; frac_x_i = ~fx; frac_y_i = ~fy;
    c = 1; ov_e = 1'b0; orow_e = 0;
    for (int i = 0; i < n; i++) begin
      for (int s = 0; s < ((base + i == stall_ofs) ? stall_len : 0); s++) begin
        ref_vld_i = 1'b0;
        @(negedge clk);
        cyc_chk({tag, ".stall"}, 1, 6'(base + i), 0, ov_e, orow_e, 1, 0, fx, fy);
        ov_e = 1'b0;
        @(posedge clk); #1; c++;
      end
      ref_vld_i = 1'b1;
      if (stray && i == 2) begin
        start_i = 1'b1; blk_h_i = 5'd4;
      end
      @(negedge clk);
      cyc_chk({tag, ".fetch"}, 1, 6'(base + i), 1, ov_e, orow_e, 1, 0, fx, fy);
      ov_e = (i >= fill - 1);
      orow_e = i - (fill - 1);
      @(posedge clk); #1; c++;
      start_i = 1'b0;
    end
    // ref_vld_i left high through DRAIN/DONE: must be ignored outside FETCH.
    @(negedge clk);
    cyc_chk({tag, ".drain"}, 0, 0, 0, ov_e, orow_e, 1, 0, fx, fy);
    @(posedge clk); #1; c++;
    @(negedge clk);
    cyc_chk({tag, ".done"}, 0, 0, 0, 0, 0, 1, 1, fx, fy);
    if (done_o) done_cyc = c;
    @(posedge clk); #1;
    ref_vld_i = 1'b0;
  endtask

  initial begin
    #2;
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Scenario 1: literal vector check of first cycles, then full block.
    run_blk("s1", 3'd3, 3'd5, 4, 99, 0, 1'b0, cyc);
    chk("s1.done_cycle", cyc, 9);

    // frac_y = 0, blk_h = 2, started back-to-back in the cycle after DONE.
    run_blk("s2", 3'd6, 3'd0, 2, 99, 0, 1'b0, cyc);
    chk("s2.done_cycle", cyc, 4);

    // Stall of 3 cycles at offset 1 delays completion by exactly 3.
    run_blk("s3", 3'd3, 3'd5, 4, 1, 3, 1'b0, cyc);
    chk("s3.done_cycle", cyc, 12);

    // Stray start while busy with different fractions on the inputs.
    run_blk("s4", 3'd1, 3'd2, 4, 99, 0, 1'b1, cyc);
    chk("s4.done_cycle", cyc, 9);

    // Illegal blk_h=5: stays idle, latched fractions unchanged.
    start_i = 1'b1; frac_x_i = 3'd6; frac_y_i = 3'd6; blk_h_i = 5'd5; ref_vld_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ill.busy", busy_o, 0);
      chk("ill.req", ref_req_o, 0);
      chk("ill.shift", win_shift_o, 0);
      chk("ill.fx", frac_x_o, 3'd1);
      chk("ill.fy", frac_y_o, 3'd2);
      @(posedge clk); #1;
    end
    ref_vld_i = 1'b0;

    // Largest block: offsets -1..17, rows 0..15.
    run_blk("s5", 3'd0, 3'd7, 16, 99, 0, 1'b0, cyc);
    chk("s5.done_cycle", cyc, 21);

    // Reset mid-FETCH at offset 2.
    start_i = 1'b1; frac_x_i = 3'd4; frac_y_i = 3'd5; blk_h_i = 5'd4; ref_vld_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    ref_vld_i = 1'b0;
    @(negedge clk);
    chk("rst.pre_row", ref_row_o, 6'd2);
    chk("rst.pre_req", ref_req_o, 1);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("rst_mid");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst.nodone", done_o, 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_blk("s6", 3'd2, 3'd1, 2, 99, 0, 1'b0, cyc);
    chk("s6.done_cycle", cyc, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
